tc_pl_cap_avg_seq_ctl: RTL and testbench

//  Sequencer for the capture accumulate datapath (ADC sample + buffer readback -> DSP add -> buffer write).

---
 rtl/tc_pl_cap_avg_seq_ctl.sv | 173 +++++++++++++++++
 tb/tb_tc_pl_cap_avg_seq_ctl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_pl_cap_avg_seq_ctl.sv
`timescale 1ns/1ps
// tc_pl_cap_avg_seq_ctl
// Sequencer for the capture/accumulate datapath. It runs cfg_frames triggered
// capture passes of cfg_len samples. Pass 0 writes raw samples and later passes
// accumulate. The block gates the ADC strobe into the datapath and waits out the
// pipeline write-back latency before it re-arms for the next trigger.
module tc_pl_cap_avg_seq_ctl #(
   parameter int LEN_W    = 16,
   parameter int CNT_W    = 16,
   parameter int PIPE_LAT = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_frames,
   input  logic             start,
   input  logic             abort,
   input  logic             trig,
   input  logic             adc_valid,
   output logic             add_add,
   output logic             data_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             err_trig_ovr
);

   // Drain counter only has to reach PIPE_LAT-1; keep it at least one bit wide.
   localparam int               DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_CAPT  = 3'd2,
      S_DRAIN = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t           state_q;

   // Configuration captured on an accepted start; later cfg_* edits are ignored.
   logic [LEN_W-1:0] len_q;
   logic [CNT_W-1:0] frames_q;

   logic [LEN_W-1:0] samp_cnt_q;
   logic [LEN_W-1:0] samp_cnt_d;
   logic [DRN_W-1:0] drain_cnt_q;
   logic [DRN_W-1:0] drain_cnt_d;
   logic [CNT_W-1:0] frame_cnt_q;
   logic [CNT_W-1:0] frame_cnt_d;

   logic             add_add_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   logic [LEN_W-1:0] len_last;
   logic             start_ok;
   logic             abort_act;
   logic             samp_last;
   logic             drain_last;
   logic             frame_last;
   logic             trig_ovr;

   // Incrementers and decode terms shared by the sequencer.
   always_comb begin
      samp_cnt_d  = samp_cnt_q + LEN_W'(1);
      drain_cnt_d = drain_cnt_q + DRN_W'(1);
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      len_last    = len_q - LEN_W'(1);
      // Abort beats a same-cycle start in IDLE, so the start is never accepted.
      start_ok    = start && !abort && (cfg_len != '0) && (cfg_frames != '0);
      abort_act   = abort && (state_q != S_IDLE);
      samp_last   = (samp_cnt_q == len_last);
      drain_last  = (drain_cnt_q == DRN_LAST);
      frame_last  = (frame_cnt_d == frames_q);
      // A trigger arriving while a frame is still being captured or written back
      // would have started a capture on top of an unfinished one.
      trig_ovr    = trig && ((state_q == S_CAPT) || (state_q == S_DRAIN));
   end

   // The sample strobe passes only while capturing. It is combinational so the
   // datapath sees the sample in the cycle it arrives, and abort blocks it at once.
   assign data_valid = adc_valid && (state_q == S_CAPT) && !abort;

   // Sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         frames_q    <= '0;
         samp_cnt_q  <= '0;
         drain_cnt_q <= '0;
         frame_cnt_q <= '0;
         add_add_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_act) begin
            // frame_cnt keeps the number of frames already written back.
            state_q   <= S_IDLE;
            add_add_q <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            if (trig_ovr) begin
               err_q <= 1'b1;
            end
            case (state_q)
               S_IDLE: begin
                  if (start_ok) begin
                     len_q       <= cfg_len;
                     frames_q    <= cfg_frames;
                     frame_cnt_q <= '0;
                     err_q       <= 1'b0;
                     add_add_q   <= 1'b0;
                     busy_q      <= 1'b1;
                     state_q     <= S_ARM;
                  end
               end
               S_ARM: begin
                  // add_add was set on entry to ARM, so it is stable well before
                  // the first gated sample of the frame.
                  if (trig) begin
                     samp_cnt_q <= '0;
                     state_q    <= S_CAPT;
                  end
               end
               S_CAPT: begin
                  if (adc_valid) begin
                     samp_cnt_q <= samp_cnt_d;
                     if (samp_last) begin
                        drain_cnt_q <= '0;
                        state_q     <= S_DRAIN;
                     end
                  end
               end
               S_DRAIN: begin
                  drain_cnt_q <= drain_cnt_d;
                  if (drain_last) begin
                     // The last sample of the frame has now reached the buffer.
                     frame_cnt_q <= frame_cnt_d;
                     if (frame_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                     end else begin
                        add_add_q <= 1'b1;
                        state_q   <= S_ARM;
                     end
                  end
               end
               S_FIN: begin
                  busy_q    <= 1'b0;
                  add_add_q <= 1'b0;
                  state_q   <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign add_add      = add_add_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign frame_cnt    = frame_cnt_q;
   assign err_trig_ovr = err_q;

endmodule

// File: tb/tb_tc_pl_cap_avg_seq_ctl.sv
`timescale 1ns/1ps
// Bench for tc_pl_cap_avg_seq_ctl: scenario table, hand sequences and random
// scenarios, each checked cycle by cycle against the frame-level rules.
module tb_tc_pl_cap_avg_seq_ctl;
   localparam int LEN_W    = 16;
   localparam int CNT_W    = 16;
   localparam int PIPE_LAT = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic [CNT_W-1:0] cfg_frames = '0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             trig = 1'b0;
   logic             adc_valid = 1'b0;
   logic             add_add;
   logic             data_valid;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] frame_cnt;
   logic             err_trig_ovr;

   always #5 clk = ~clk;

   tc_pl_cap_avg_seq_ctl #(
      .LEN_W(LEN_W), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_frames(cfg_frames),
      .start(start), .abort(abort), .trig(trig), .adc_valid(adc_valid),
      .add_add(add_add), .data_valid(data_valid), .busy(busy), .done(done),
      .frame_cnt(frame_cnt), .err_trig_ovr(err_trig_ovr)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int g_dv, g_done;
   int o_dv, o_busy, o_add, o_done, o_fcnt, o_err;

   typedef struct {
      int len; int frames; int gap; bit xtrig; int abf; int aba;
      int e_dv; int e_done; int e_fcnt; int e_err;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic smp();
      o_dv   = int'(data_valid);
      o_busy = int'(busy);
      o_add  = int'(add_add);
      o_done = int'(done);
      o_fcnt = int'(frame_cnt);
      o_err  = int'(err_trig_ovr);
   endtask

   // One clock cycle: drive inputs just after the edge, sample mid-cycle.
   task automatic cyc(input bit st, input bit tr, input bit av, input bit ab);
      start = st; trig = tr; adc_valid = av; abort = ab;
      #1;
      smp();
      g_dv   += o_dv;
      g_done += o_done;
      @(posedge clk);
      #1;
   endtask

   // Expected values for the sampled cycle; -1 means not checked.
   task automatic ex(input string tag, input int e_dv, input int e_busy, input int e_add,
                     input int e_done, input int e_fcnt, input int e_err);
      if (e_dv   >= 0) chk({tag, " data_valid"},   o_dv,   e_dv);
      if (e_busy >= 0) chk({tag, " busy"},         o_busy, e_busy);
      if (e_add  >= 0) chk({tag, " add_add"},      o_add,  e_add);
      if (e_done >= 0) chk({tag, " done"},         o_done, e_done);
      if (e_fcnt >= 0) chk({tag, " frame_cnt"},    o_fcnt, e_fcnt);
      if (e_err  >= 0) chk({tag, " err_trig_ovr"}, o_err,  e_err);
   endtask

   // Runs one full sequence from IDLE. Stimulus is generated frame by frame and every
   // cycle is checked against what the frame rules say must be visible.
   task automatic run_seq(input int len, input int frames, input int gap_pct, input bit xtrig,
                          input int ab_frame, input int ab_after,
                          output int dv_cnt, output int done_cnt, output int fcnt_end,
                          output int err_end);
      int  k, budget, exp_err, arm_n, ad;
      bit  ab_hit, av, tr;
      g_dv = 0; g_done = 0; exp_err = 0; ab_hit = 1'b0;
      cfg_len    = LEN_W'(len);
      cfg_frames = CNT_W'(frames);
      // trig and adc_valid alongside start must not count.
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      ex("start", 0, 0, -1, 0, -1, -1);
      for (int f = 0; f < frames && !ab_hit; f++) begin
         ad    = (f > 0) ? 1 : 0;
         arm_n = 1 + int'($urandom_range(0, 3));
         for (int i = 0; i < arm_n; i++) begin
            // Restarts and config edits while busy must have no effect.
            cfg_len    = LEN_W'($urandom);
            cfg_frames = CNT_W'($urandom);
            cyc(1'($urandom_range(0, 1)), 1'b0, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
            ex("arm", 0, 1, ad, 0, f, exp_err);
         end
         cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
         ex("arm trig", 0, 1, ad, 0, f, exp_err);
         k = 0; budget = 0;
         while (k < len) begin
            if (f == ab_frame && k == ab_after) begin
               cyc(1'b0, 1'b0, 1'b1, 1'b1);
               ex("abort cycle", 0, 1, ad, 0, f, exp_err);
               ab_hit = 1'b1;
               break;
            end
            av = (int'($urandom_range(0, 99)) >= gap_pct);
            tr = xtrig && (f == 0) && (k == 1);
            cyc(1'($urandom_range(0, 1)), tr, av, 1'b0);
            ex("capture", av ? 1 : 0, 1, ad, 0, f, exp_err);
            if (tr) exp_err = 1;
            if (av) k++;
            budget++;
            if (budget > 5000) begin
               n_chk++; n_fail++;
               $display("FAIL capture budget: got %0d valid, expected %0d", k, len);
               break;
            end
         end
         if (ab_hit) begin
            repeat (2) begin
               cyc(1'b0, 1'b1, 1'b1, 1'b0);
               ex("post abort", 0, 0, 0, 0, f, exp_err);
            end
         end else begin
            for (int d = 0; d < PIPE_LAT; d++) begin
               tr = xtrig && (f == 0) && (len == 1) && (d == 0);
               cyc(1'b0, tr, 1'($urandom_range(0, 1)), 1'b0);
               ex("drain", 0, 1, ad, 0, f, exp_err);
               if (tr) exp_err = 1;
            end
         end
      end
      if (!ab_hit) begin
         cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         ex("fin", 0, 1, -1, 1, frames, exp_err);
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
         ex("idle after", 0, 0, 0, 0, frames, exp_err);
      end
      dv_cnt = g_dv; done_cnt = g_done; fcnt_end = o_fcnt; err_end = o_err;
   endtask

   task automatic check_seq(input string tag, input vec_t v);
      int dv, dn, fc, er;
      run_seq(v.len, v.frames, v.gap, v.xtrig, v.abf, v.aba, dv, dn, fc, er);
      chk({tag, " total data_valid"}, dv, v.e_dv);
      chk({tag, " done pulses"},      dn, v.e_done);
      chk({tag, " final frame_cnt"},  fc, v.e_fcnt);
      chk({tag, " final err"},        er, v.e_err);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      // len, frames, gap%, xtrig, abort frame, abort after, e_dv, e_done, e_fcnt, e_err
      tbl[0] = '{4,  1, 0,  1'b0, -1, 0, 4,  1, 1, 0};
      tbl[1] = '{8,  3, 40, 1'b0, -1, 0, 24, 1, 3, 0};
      tbl[2] = '{4,  2, 0,  1'b1, -1, 0, 8,  1, 2, 1};
      tbl[3] = '{16, 4, 20, 1'b0, 2,  5, 37, 0, 2, 0};
      tbl[4] = '{1,  2, 30, 1'b1, -1, 0, 2,  1, 2, 1};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      adc_valid = 1'b1;
      #1;
      smp();
      ex("reset", 0, 0, 0, 0, 0, 0);
      adc_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) begin
         check_seq($sformatf("table%0d", i), tbl[i]);
      end

      // Starts with a zero config, or with abort in the same cycle, are ignored.
      cfg_len = 16'd0; cfg_frames = 16'd2;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      ex("len0 start", 0, 0, 0, 0, -1, -1);
      cfg_len = 16'd4; cfg_frames = 16'd0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      ex("frames0 start", 0, 0, 0, 0, -1, -1);
      cfg_len = 16'd4; cfg_frames = 16'd1;
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      ex("start with abort", 0, 0, 0, 0, -1, -1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ex("start with abort next", 0, 0, 0, 0, -1, -1);

      // Reset in the drain of frame 1 with err set and add_add high.
      cfg_len = 16'd3; cfg_frames = 16'd2;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (PIPE_LAT) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      ex("pre reset", 0, 1, 1, 0, 1, 1);
      rst_n = 1'b0;
      adc_valid = 1'b1;
      #1;
      smp();
      ex("async reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      adc_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_seq("after reset", tbl[0]);

      // Random scenarios; expectations from the frame arithmetic.
      for (int r = 0; r < 6; r++) begin
         rv.len    = int'($urandom_range(1, 10));
         rv.frames = int'($urandom_range(1, 4));
         rv.gap    = int'($urandom_range(0, 60));
         rv.xtrig  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) begin
            rv.abf = int'($urandom_range(0, rv.frames - 1));
            rv.aba = int'($urandom_range(0, rv.len - 1));
         end else begin
            rv.abf = -1;
            rv.aba = 0;
         end
         if (rv.abf >= 0) begin
            rv.e_dv   = rv.abf * rv.len + rv.aba;
            rv.e_done = 0;
            rv.e_fcnt = rv.abf;
         end else begin
            rv.e_dv   = rv.len * rv.frames;
            rv.e_done = 1;
            rv.e_fcnt = rv.frames;
         end
         // The stray trigger lands early in frame 0; an abort before it prevents it.
         rv.e_err = (rv.xtrig && !(rv.abf == 0 && rv.aba <= 1)) ? 1 : 0;
         check_seq($sformatf("rand%0d len%0d fr%0d", r, rv.len, rv.frames), rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
